// File: rtl/dpm_port_arbiter_pkg.sv
// dpm_arb_pkg: shared FSM state type, counter width and round-robin pick for the port arbiter
package dpm_arb_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam int CNT_W = 16;
  localparam int MAX_REQ = 8;
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] last, input int n);
    logic [MAX_REQ-1:0] g;
    logic [2:0] idx;
    g = '0;
    // Scan farthest-first so the nearest request after last wins
    for (int i = MAX_REQ; i >= 1; i--) begin
      idx = 3'((int'(last) + i) % n);
      if (i <= n && req[idx]) g = MAX_REQ'(1) << idx;
    end
    return g;
  endfunction
endpackage

// File: rtl/dpm_port_arbiter_if.sv
// dpm_mem_if: one port of the dual-port memory; master drives the command, slave returns read data
interface dpm_mem_if #(parameter int WIDTH = 12, parameter int ADDR_WIDTH = 10);
  logic en;
  logic we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  modport master(output en, we, addr, din, input dout);
  modport slave(input en, we, addr, din, output dout);
endinterface

// File: rtl/dpm_rr_arbiter.sv
// dpm_rr_arbiter: round-robin pointer plus combinational one-hot grant and its index
module dpm_rr_arbiter import dpm_arb_pkg::*; #(
  parameter int NREQ = 4,
  localparam int LW = $clog2(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [NREQ-1:0] i_req,
  output logic [NREQ-1:0] o_gnt,
  output logic [LW-1:0]   o_idx
);
  logic [LW-1:0] r_last;
  assign o_gnt = i_en ? NREQ'(rr_pick(MAX_REQ'(i_req), 3'(r_last), NREQ)) : '0;
  always_comb begin
    o_idx = '0;
    for (int k = 0; k < NREQ; k++) if (o_gnt[k]) o_idx = LW'(k);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) r_last <= LW'(NREQ - 1);
    else if (|(i_req & o_gnt)) r_last <= o_idx;
  end
endmodule

// File: rtl/dpm_port_arbiter.sv
// dpm_port_arbiter: zero-fills then round-robin shares one memory port; DPM_ARB_PERF_EN adds grant counters
module dpm_port_arbiter import dpm_arb_pkg::*; #(
  parameter int WIDTH = 12,
  parameter int ADDR_WIDTH = 10,
  parameter int NREQ = 4,
  parameter int READ_LAT = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ-1:0]          i_we,
  input  logic [NREQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NREQ*WIDTH-1:0]    i_din,
  output logic [NREQ-1:0]          o_gnt,
  output logic [NREQ-1:0]          o_rvalid,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_init_done,
`ifdef DPM_ARB_PERF_EN
  input  logic                     i_cnt_clr,
  output logic [NREQ*CNT_W-1:0]    o_gnt_cnt,
`endif
  dpm_mem_if.master                mem
);
  localparam int LW = $clog2(NREQ);
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_cnt, r_mem_addr;
  logic [WIDTH-1:0] r_mem_din;
  logic r_mem_en, r_mem_we, r_init_done;
  logic [NREQ-1:0] r_tag [READ_LAT];
  logic [NREQ-1:0] r_rvalid, w_push;
  logic [LW-1:0] w_idx;
  logic w_xfer;
  dpm_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(r_init_done), .i_req(i_req), .o_gnt(o_gnt), .o_idx(w_idx)
  );
  assign w_xfer = |(i_req & o_gnt);
  assign w_push = (w_xfer && !i_we[w_idx]) ? o_gnt : '0;
  assign w_next = (r_state == INIT && &r_cnt) ? RUN : r_state;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= INIT;
      r_cnt <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= r_cnt + ADDR_WIDTH'(r_state == INIT);
      r_init_done <= r_state == RUN;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din <= '0;
    end else if (r_state == INIT) begin
      r_mem_en <= 1'b1;
      r_mem_we <= 1'b1;
      r_mem_addr <= r_cnt;
      r_mem_din <= '0;
    end else if (w_xfer) begin
      r_mem_en <= 1'b1;
      r_mem_we <= i_we[w_idx];
      r_mem_addr <= i_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
      r_mem_din <= i_din[w_idx*WIDTH +: WIDTH];
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
    end
  end
  // Tags travel alongside the read so o_rvalid lands with the memory's unregistered dout
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int j = 0; j < READ_LAT; j++) r_tag[j] <= '0;
      r_rvalid <= '0;
    end else begin
      r_tag[0] <= w_push;
      for (int j = 1; j < READ_LAT; j++) r_tag[j] <= r_tag[j-1];
      r_rvalid <= r_tag[READ_LAT-1];
    end
  end
  assign mem.en = r_mem_en;
  assign mem.we = r_mem_we;
  assign mem.addr = r_mem_addr;
  assign mem.din = r_mem_din;
  assign o_rvalid = r_rvalid;
  assign o_rdata = mem.dout;
  assign o_init_done = r_init_done;
`ifdef DPM_ARB_PERF_EN
  logic [CNT_W-1:0] r_gcnt [NREQ];
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NREQ; k++) begin
      if (i_rst || i_cnt_clr) r_gcnt[k] <= '0;
      else if (i_req[k] && o_gnt[k] && !(&r_gcnt[k])) r_gcnt[k] <= r_gcnt[k] + 1'b1;
    end
  end
  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign o_gnt_cnt[g*CNT_W +: CNT_W] = r_gcnt[g];
  end
`endif
endmodule

// File: tb/tb_dpm_port_arbiter.sv
// tb_dpm_port_arbiter: directed checks of fill, arbitration, read return and reset on a behavioural memory
module tb_dpm_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] i_req, i_we, o_gnt, o_rvalid;
  logic [39:0] i_addr;
  logic [47:0] i_din;
  logic [11:0] o_rdata;
  logic o_init_done;
  logic [11:0] mem_arr [1024];
  int n_chk = 0;
  int n_fail = 0;
`ifdef DPM_ARB_PERF_EN
  logic i_cnt_clr;
  logic [63:0] o_gnt_cnt;
`endif
  dpm_mem_if #(.WIDTH(12), .ADDR_WIDTH(10)) mif ();
  dpm_port_arbiter #(.WIDTH(12), .ADDR_WIDTH(10), .NREQ(4), .READ_LAT(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_din(i_din),
    .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_init_done(o_init_done),
`ifdef DPM_ARB_PERF_EN
    .i_cnt_clr(i_cnt_clr), .o_gnt_cnt(o_gnt_cnt),
`endif
    .mem(mif.master)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mif.en) begin
      if (mif.we) mem_arr[mif.addr] <= mif.din;
      else mif.dout <= mem_arr[mif.addr];
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_slot(input int k, input logic we, input logic [9:0] addr, input logic [11:0] din);
    i_we[k] = we;
    i_addr[k*10 +: 10] = addr;
    i_din[k*12 +: 12] = din;
  endtask
  initial begin
    logic [3:0] eg, er;
    rst = 1'b1; i_req = '0; i_we = '0; i_addr = '0; i_din = '0;
`ifdef DPM_ARB_PERF_EN
    i_cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {o_gnt, o_rvalid, o_init_done, mif.en, mif.we, mif.addr, mif.din}, 32'h0);
    rst = 1'b0;
    i_req = 4'b1111;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      chk("init_fill", {o_gnt, o_init_done, mif.en, mif.we, mif.addr, mif.din}, {4'b0, 1'b0, 1'b1, 1'b1, 10'(i), 12'h0});
    end
    i_req = '0;
    @(negedge clk);
    chk("init_done", {o_init_done, mif.en}, 2'b10);
    set_slot(2, 1'b1, 10'h005, 12'hABC);
    i_req = 4'b0100;
    #1 chk("wr_gnt", o_gnt, 4'b0100);
    @(negedge clk);
    chk("wr_cmd", {mif.en, mif.we, mif.addr, mif.din}, {1'b1, 1'b1, 10'h005, 12'hABC});
    set_slot(2, 1'b0, 10'h005, 12'h000);
    #1 chk("rd_gnt", o_gnt, 4'b0100);
    @(negedge clk);
    chk("rd_cmd", {mif.en, mif.we, mif.addr, o_rvalid}, {1'b1, 1'b0, 10'h005, 4'b0000});
    i_req = '0;
    @(negedge clk);
    chk("rd_ret", {o_rvalid, o_rdata, mif.en}, {4'b0100, 12'hABC, 1'b0});
    @(negedge clk);
    chk("rd_once", o_rvalid, 4'b0000);
    set_slot(0, 1'b0, 10'h005, 12'h0);
    set_slot(1, 1'b0, 10'h001, 12'h0);
    set_slot(2, 1'b0, 10'h002, 12'h0);
    set_slot(3, 1'b0, 10'h003, 12'h0);
    for (int i = 0; i < 10; i++) begin
      i_req = (i < 8) ? 4'b1111 : 4'b0000;
      eg = (i < 8) ? 4'b0001 << ((3 + i) % 4) : 4'b0000;
      #1 chk("rr_gnt", o_gnt, eg);
      if (i >= 2) begin
        er = 4'b0001 << ((3 + i - 2) % 4);
        chk("rr_rvalid", o_rvalid, er);
        chk("rr_rdata", o_rdata, (er == 4'b0001) ? 12'hABC : 12'h000);
      end
      @(negedge clk);
    end
    chk("rr_tail", o_rvalid, 4'b0000);
    i_req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1 chk("lone_gnt", o_gnt, 4'b0010);
      @(negedge clk);
    end
    i_req = 4'b0011;
    #1 chk("pair_first", o_gnt, 4'b0001);
    @(negedge clk);
    #1 chk("pair_second", o_gnt, 4'b0010);
    i_req = 4'b0010;
    @(negedge clk);
    chk("pre_rst_rvalid", o_rvalid, 4'b0001);
    rst = 1'b1;
    i_req = '0;
    @(negedge clk);
    chk("rst_flush", {o_rvalid, o_init_done, mif.en, mif.we, o_gnt}, 11'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("refill_0", {o_rvalid, mif.en, mif.we, mif.addr, mif.din}, {4'b0, 1'b1, 1'b1, 10'h000, 12'h0});
    @(negedge clk);
    chk("refill_1", {o_rvalid, o_init_done, mif.en, mif.we, mif.addr}, {4'b0, 1'b0, 1'b1, 1'b1, 10'h001});
    repeat (1023) @(negedge clk);
    chk("reinit_done", o_init_done, 1'b1);
`ifdef DPM_ARB_PERF_EN
    chk("cnt_rst", o_gnt_cnt[31:0], 32'h0);
    i_req = 4'b0001;
    repeat (70000) @(negedge clk);
    chk("cnt_sat", o_gnt_cnt[15:0], 16'hFFFF);
    chk("cnt_other", o_gnt_cnt[31:16], 16'h0);
    i_cnt_clr = 1'b1;
    @(negedge clk);
    i_cnt_clr = 1'b0;
    chk("cnt_clr", o_gnt_cnt[15:0], 16'h0);
    @(negedge clk);
    chk("cnt_after_clr", o_gnt_cnt[15:0], 16'h1);
    i_req = '0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dpm_port_arbiter.md
Name: dpm_port_arbiter

Overview:
- Shares one port of the dual-port memory among NREQ requesters using round-robin arbitration.
- Presents a valid/grant request channel to each requester and drives the memory port's en/we/addr/din from registers.
- Returns read data to the winning requester with a tagged valid.
- After reset, zero-fills the whole memory before accepting any request. One instance sits on port A, another on port B.

Parameters:
- WIDTH, 12, data word width.
- ADDR_WIDTH, 10, memory address width; depth = 2**ADDR_WIDTH.
- NREQ, 4, number of requesters (2..8).
- READ_LAT, 1, memory read latency in cycles from registered en to valid dout (1..3).

Ports:
- i_clk  in  1  single clock for the block and the memory port it drives.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  NREQ  per-requester request valid.
- i_we  in  NREQ  per-requester write (1) / read (0).
- i_addr  in  NREQ*ADDR_WIDTH  packed addresses; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_din  in  NREQ*WIDTH  packed write data, same packing.
- o_gnt  out  NREQ  one-hot grant; a transfer occurs on the clock edge where i_req[k] and o_gnt[k] are both high.
- o_rvalid  out  NREQ  one-hot read-data valid.
- o_rdata  out  WIDTH  read data, shared by all requesters, qualified by o_rvalid.
- o_init_done  out  1  high once zero-fill has completed.
- o_mem_en, o_mem_we  out  1 each  memory port enable and write enable.
- o_mem_addr  out  ADDR_WIDTH  memory port address.
- o_mem_din  out  WIDTH  memory port write data.
- i_mem_dout  in  WIDTH  memory port read data.

Behaviour:
- Reset values: o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_din=0, o_rvalid=0, o_init_done=0, o_gnt=0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
  - Read-tag pipeline is cleared.
- FSM states: INIT, RUN.
  - Reset enters INIT with the fill counter at 0.
  - INIT: each cycle, register en=1, we=1, addr=counter, din=0, then increment the counter.
  - When the counter reaches depth-1 and that write has issued, go to RUN and set o_init_done=1 on the following cycle.
  - o_gnt is 0 throughout INIT; requests are held off and not dropped.
- RUN arbitration (combinational o_gnt):
  - Grant the first k with i_req[k]=1, searching from last+1 upward and wrapping modulo NREQ.
  - No request gives o_gnt=0.
  - On a transfer, last takes the value k.
  - One grant per cycle, so back-to-back throughput is one transfer per cycle.
- Command issue (transfer at edge t):
  - o_mem_en=1, o_mem_we=i_we[k], o_mem_addr and o_mem_din taken from slot k, all valid in cycle t+1.
  - With no transfer: o_mem_en=0, o_mem_we=0; addr and din hold their previous values.
- Read return:
  - Each read pushes a one-hot tag into a READ_LAT-deep shift register.
  - o_rvalid = tag registered to align with data; o_rdata = i_mem_dout unregistered.
  - o_rvalid[k] is high in cycle t+1+READ_LAT, exactly once per read.
  - Writes produce no o_rvalid.
- Fairness: with all requests held high, grants rotate 0,1,...,NREQ-1,0. A lone requester is granted every cycle.
- Requester dropping i_req before its grant: no transfer occurs and the pointer is unchanged.
- Reset mid-INIT or mid-RUN:
  - Returns to INIT at counter 0 and discards in-flight read tags; no o_rvalid is emitted for them.
  - The memory is re-filled.
- Same address written and read in consecutive cycles: the read returns whatever the memory provides. The arbiter adds no forwarding.

Optional Feature:
- Macro DPM_ARB_PERF_EN.
- When defined:
  - Adds output o_gnt_cnt, NREQ*16 bits: per-requester 16-bit grant counters.
  - Counters increment on each transfer, saturate at 16'hFFFF, and clear on i_rst.
  - Adds input i_cnt_clr (1 bit), which clears all counters synchronously. A clear and an increment in the same cycle gives 0.
- When undefined: neither port nor any counter logic exists, and behaviour is otherwise identical.

Decomposition:
- Package dpm_arb_pkg:
  - State enum {INIT, RUN}.
  - Localparam CNT_W=16.
  - A function rr_pick(req, last) returning a one-hot grant.
- Sub-module dpm_rr_arbiter (NREQ): pointer register plus the combinational pick. The top holds the FSM, command registers and tag pipeline.

Test Plan:
- Reset with defaults: 1024 consecutive writes of data 0 at addresses 0..1023, then o_init_done=1 in cycle 1025 after reset; any i_req during INIT sees o_gnt=0.
- After init, requester 2 writes 12'hABC to 0x05, then reads 0x05: o_rvalid=4'b0100 two cycles after the read grant, o_rdata=12'hABC.
- All four requesters read continuously: grant order 0,1,2,3,0,...; each o_rvalid is one-hot and matches the requester granted READ_LAT+1 cycles earlier.
- Requester 1 alone holds i_req for 5 cycles: 5 consecutive grants; then requesters 0 and 1 together: 0 is granted first (pointer at 1).
- Reset asserted 2 cycles after a read grant: no o_rvalid appears, INIT restarts at address 0, and o_init_done drops to 0.
- With DPM_ARB_PERF_EN: 70000 grants to requester 0 leaves its counter at 16'hFFFF; i_cnt_clr pulsed together with a grant gives a count of 0.
